// File: rtl/hex_scan_ctrl_pkg.sv
// Shared constants and helpers for the hex display scan controller.
// Imported by the top and by the slot timer.
package hex_scan_ctrl_pkg;

  localparam int unsigned DEF_SLOT_CLKS = 50000;
  localparam int unsigned DEF_GUARD     = 64;

  // Minimum bit width able to hold the values 0 .. n-1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_scan_ctrl_scan_timer.sv
// Digit-slot timer: free-running counter over one slot, flags the last cycle of the slot
// and whether the upcoming cycle falls in the anti-ghosting guard window.
module hex_scan_ctrl_scan_timer
  import hex_scan_ctrl_pkg::*;
#(
  parameter int unsigned SLOT_CLKS = DEF_SLOT_CLKS,
  parameter int unsigned GUARD     = DEF_GUARD
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic slot_wrap_o,
  output logic in_guard_o
);

  localparam int unsigned CntW = clog2(SLOT_CLKS);
  localparam logic [CntW-1:0] CntLast  = CntW'(SLOT_CLKS - 1);
  localparam logic [CntW-1:0] CntGuard = CntW'(GUARD);

  logic [CntW-1:0] slot_cnt_q, slot_cnt_d;

  always_comb begin
    slot_wrap_o = (slot_cnt_q == CntLast);
    slot_cnt_d  = slot_wrap_o ? '0 : slot_cnt_q + 1'b1;
    // Guard status of the next cycle, so the top can register dig_n in step with the count.
    in_guard_o  = (slot_cnt_d < CntGuard);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_cnt_q <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
    end
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode hex display. A loaded value is held
// pending and committed only at a frame boundary so a frame never mixes old and new digits.
module hex_scan_ctrl
  import hex_scan_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SLOT_CLKS = DEF_SLOT_CLKS,
  parameter int unsigned GUARD     = DEF_GUARD,
  parameter int unsigned BLANK_LZ  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [DIGITS*4-1:0] value,
  output logic [3:0]          hex,
  output logic [DIGITS-1:0]   dig_n,
  output logic                blank,
  output logic                pending,
  output logic                frame_done
);

  localparam int unsigned IdxW = clog2(DIGITS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [DIGITS*4-1:0] shown_q, shown_d;
  logic [DIGITS*4-1:0] pend_val_q, pend_val_d;
  logic                pending_q, pending_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [3:0]          hex_q, hex_d;
  logic [DIGITS-1:0]   dig_n_q, dig_n_d;
  logic                blank_q, blank_d;
  logic                frame_done_q, frame_done_d;

  logic                slot_wrap;
  logic                guard_next;
  logic                idx_last;
  logic                commit;
  logic                higher_zero;
  logic [DIGITS-1:0]   lz;

  hex_scan_ctrl_scan_timer #(
    .SLOT_CLKS (SLOT_CLKS),
    .GUARD     (GUARD)
  ) u_scan_timer (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .slot_wrap_o (slot_wrap),
    .in_guard_o  (guard_next)
  );

  always_comb begin
    idx_last = (idx_q == IdxLast);
    commit   = slot_wrap && idx_last;

    idx_d = idx_q;
    if (slot_wrap) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end

    // A load on the commit edge refills pending_val while the old value goes to shown.
    pend_val_d   = load ? value : pend_val_q;
    pending_d    = load | (pending_q & ~commit);
    shown_d      = (commit && pending_q) ? pend_val_q : shown_q;
    frame_done_d = commit;

    higher_zero = 1'b1;
    lz          = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      higher_zero = higher_zero & (shown_d[4*i +: 4] == 4'h0);
      lz[i]       = higher_zero & (i != 0) & (BLANK_LZ != 0);
    end

    // Outputs are computed from next-state so the registered outputs track idx/slot exactly.
    hex_d   = 4'h0;
    blank_d = 1'b0;
    dig_n_d = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_d == IdxW'(i)) begin
        hex_d      = shown_d[4*i +: 4];
        blank_d    = lz[i];
        dig_n_d[i] = guard_next | lz[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shown_q      <= '0;
      pend_val_q   <= '0;
      pending_q    <= 1'b0;
      idx_q        <= '0;
      hex_q        <= 4'h0;
      dig_n_q      <= '1;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      shown_q      <= shown_d;
      pend_val_q   <= pend_val_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      hex_q        <= hex_d;
      dig_n_q      <= dig_n_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign hex        = hex_q;
  assign dig_n      = dig_n_q;
  assign blank      = blank_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl (DIGITS=4, SLOT_CLKS=8, GUARD=2, BLANK_LZ=1).
// Stimulus queues the expected frame contents; a monitor checks each frame after frame_done.
module tb_hex_scan_ctrl;

  localparam int unsigned SLOT  = 8;
  localparam int unsigned GUARD = 2;
  localparam int unsigned FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  hex;
  logic [3:0]  dig_n;
  logic        blank;
  logic        pending;
  logic        frame_done;

  hex_scan_ctrl #(
    .DIGITS    (4),
    .SLOT_CLKS (SLOT),
    .GUARD     (GUARD),
    .BLANK_LZ  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value      (value),
    .hex        (hex),
    .dig_n      (dig_n),
    .blank      (blank),
    .pending    (pending),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] nibs;   // expected hex per slot, slot k = nibs[4k+3:4k]
    logic [3:0]  blank;  // expected blank per slot
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor state
  exp_t       mon_cur;
  bit         mon_cap = 1'b0;
  bit         mon_fd_seen = 1'b0;
  int         mon_off = 0;
  int         mon_cyc = 0;
  int         mon_last_fd = 0;
  int         mon_k;
  int         mon_ph;
  logic [3:0] mon_dig;

  initial begin : monitor
    forever begin
      @(negedge clk);
      mon_cyc++;
      if (!rst_n) begin
        mon_cap     = 1'b0;
        mon_fd_seen = 1'b0;
      end else begin
        if (frame_done) begin
          if (mon_fd_seen) check("frame_period", mon_cyc - mon_last_fd, FRAME);
          mon_last_fd = mon_cyc;
          mon_fd_seen = 1'b1;
          if (exp_q.size() > 0) begin
            mon_cur = exp_q.pop_front();
            mon_cap = 1'b1;
            mon_off = 0;
          end
        end
        if (mon_cap) begin
          mon_k  = mon_off / SLOT;
          mon_ph = mon_off % SLOT;
          if (mon_ph == 0) begin
            check($sformatf("guard_dig_n[%0d]", mon_k), dig_n, 4'hF);
            check($sformatf("guard_hex[%0d]", mon_k), hex, mon_cur.nibs[4*mon_k +: 4]);
          end else if (mon_ph == GUARD || mon_ph == SLOT - 1) begin
            mon_dig = mon_cur.blank[mon_k] ? 4'hF : ~(4'h1 << mon_k);
            check($sformatf("act_dig_n[%0d]", mon_k), dig_n, mon_dig);
            check($sformatf("act_hex[%0d]", mon_k), hex, mon_cur.nibs[4*mon_k +: 4]);
            check($sformatf("act_blank[%0d]", mon_k), blank, mon_cur.blank[mon_k]);
          end
          mon_off++;
          if (mon_off == FRAME) mon_cap = 1'b0;
        end
      end
    end
  end

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 100);
    check("frame_done_seen", frame_done, 1'b1);
  endtask

  task automatic load_val(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic release_and_check();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_guard_dig_n", dig_n, 4'hF);
    @(negedge clk);
    check("post_rst_first_dig_n", dig_n, 4'b1110);
    check("post_rst_first_hex", hex, 4'h0);
    check("post_rst_pending", pending, 1'b0);
  endtask

  initial begin : stim
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hex", hex, 4'h0);
    check("rst_dig_n", dig_n, 4'hF);
    check("rst_blank", blank, 1'b0);
    check("rst_pending", pending, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    exp_q.push_back('{nibs: 16'h0000, blank: 4'b1110});
    release_and_check();

    // Mid-frame load of 1A2F, held pending until the next idx-0 slot
    wait_fd();
    repeat (3) @(negedge clk);
    load_val(16'h1A2F);
    check("load_pending", pending, 1'b1);
    exp_q.push_back('{nibs: 16'h1A2F, blank: 4'b0000});
    repeat (10) @(negedge clk);
    check("pending_held", pending, 1'b1);
    wait_fd();
    check("commit_pending_clr", pending, 1'b0);

    // Leading-zero blanking
    repeat (3) @(negedge clk);
    load_val(16'h003C);
    exp_q.push_back('{nibs: 16'h003C, blank: 4'b1100});
    wait_fd();
    repeat (3) @(negedge clk);
    load_val(16'h0000);
    exp_q.push_back('{nibs: 16'h0000, blank: 4'b1110});
    wait_fd();

    // Two loads in one frame: last wins
    repeat (3) @(negedge clk);
    load_val(16'h1111);
    repeat (5) @(negedge clk);
    load_val(16'h2222);
    exp_q.push_back('{nibs: 16'h2222, blank: 4'b0000});
    wait_fd();

    // Load on the commit edge: old pending shown now, new one next frame
    repeat (3) @(negedge clk);
    load_val(16'h5555);
    exp_q.push_back('{nibs: 16'h5555, blank: 4'b0000});
    exp_q.push_back('{nibs: 16'h6666, blank: 4'b0000});
    repeat (27) @(negedge clk);
    value = 16'h6666;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("commit_edge_frame_done", frame_done, 1'b1);
    check("commit_edge_pending", pending, 1'b1);
    wait_fd();
    check("second_commit_pending", pending, 1'b0);

    // Reset during digit 2 active window drops display and pending value
    wait_fd();
    repeat (10) @(negedge clk);
    load_val(16'h7777);
    check("pre_rst_pending", pending, 1'b1);
    repeat (9) @(negedge clk);
    check("pre_rst_dig_n", dig_n, 4'b1011);
    check("pre_rst_hex", hex, 4'h6);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dig_n", dig_n, 4'hF);
    check("async_rst_hex", hex, 4'h0);
    check("async_rst_pending", pending, 1'b0);
    check("async_rst_blank", blank, 1'b0);
    check("async_rst_frame_done", frame_done, 1'b0);
    exp_q.push_back('{nibs: 16'h0000, blank: 4'b1110});
    release_and_check();
    wait_fd();
    repeat (FRAME + 2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
